sdram_req_arbiter: RTL and testbench

Two-port arbiter that shares the single SDRAM controller request interface (wr_req/wr_ack, rd_req/rd_ack, address, write/read data) between two requesters. Typical pairing: the UART debug MCU as one requester and a streaming engine as the other. The block serialises accesses with round-robin fairness and sequences each request/acknowledge handshake. It returns read data and a completion pulse to the winning requester.

---
 rtl/sdram_req_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arbiter.sv
// Round-robin two-port arbiter sharing one SDRAM controller request port.
// Define ARB_TIMEOUT_EN to bound WAIT with an 8-bit abort timer (TIMEOUT).
`timescale 1ns/1ps
module sdram_req_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0_wr,
  input  logic              req0_rd,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_wr,
  input  logic              req1_rd,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic              sdram_wr_req,
  input  logic              sdram_wr_ack,
  output logic              sdram_rd_req,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_din,
  input  logic [DATA_W-1:0] sdram_dout,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              v0, v1, pick1, grant;
  logic              ack_hit, tmo_hit, fin;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              op_wr_q, op_wr_d;
  logic              gid_q, gid_d;
  logic              last_q, last_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // On a tie the requester that did not win last time is served
  assign v0      = req0_wr | req0_rd;
  assign v1      = req1_wr | req1_rd;
  assign pick1   = v1 & (~v0 | ~last_q);
  assign grant   = v0 | v1;
  assign ack_hit = op_wr_q ? sdram_wr_ack : sdram_rd_ack;
  assign fin     = (state_q == S_WAIT) & (ack_hit | tmo_hit);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [7:0] timer_q, timer_d, timer_inc;
  logic       err0_q, err0_d;
  logic       err1_q, err1_d;

  // An ack landing on the timeout cycle takes priority
  assign timer_inc = timer_q + 8'd1;
  assign tmo_hit   = (state_q == S_WAIT) &
                     (timer_inc == TMO) & ~ack_hit;

  always_comb begin
    timer_d = timer_q;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    unique case (state_q)
      S_ISSUE: timer_d = 8'd0;
      S_WAIT: begin
        timer_d = timer_inc;
        err0_d  = tmo_hit & ~gid_q;
        err1_d  = tmo_hit & gid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_q <= 8'd0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign req0_err = err0_q;
  assign req1_err = err1_q;
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign req0_err   = 1'b0;
  assign req1_err   = 1'b0;
  assign unused_tmo = (TIMEOUT != 0);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (fin) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    din_d    = din_q;
    op_wr_d  = op_wr_q;
    gid_d    = gid_q;
    last_d   = last_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          gid_d   = pick1;
          last_d  = pick1;
          addr_d  = pick1 ? req1_addr : req0_addr;
          din_d   = pick1 ? req1_wdata : req0_wdata;
          op_wr_d = pick1 ? req1_wr : req0_wr;
        end
      end
      S_ISSUE: begin
        wr_req_d = op_wr_q;
        rd_req_d = ~op_wr_q;
      end
      S_WAIT: begin
        if (fin) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          done0_d  = ~gid_q;
          done1_d  = gid_q;
          if (ack_hit & ~op_wr_q) begin
            if (gid_q) rdata1_d = sdram_dout;
            else       rdata0_d = sdram_dout;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q   <= '0;
      din_q    <= '0;
      op_wr_q  <= 1'b0;
      gid_q    <= 1'b0;
      last_q   <= 1'b1;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      addr_q   <= addr_d;
      din_q    <= din_d;
      op_wr_q  <= op_wr_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign sdram_addr   = addr_q;
  assign sdram_din    = din_q;
  assign sdram_wr_req = wr_req_q;
  assign sdram_rd_req = rd_req_q;
  assign req0_done    = done0_q;
  assign req1_done    = done1_q;
  assign req0_rdata   = rdata0_q;
  assign req1_rdata   = rdata1_q;
  assign grant_id     = gid_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: grant model, SDRAM memory model.
`timescale 1ns/1ps
module tb_sdram_req_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req0_wr = 0, req0_rd = 0;
  logic [23:0] req0_addr = '0;
  logic [15:0] req0_wdata = '0;
  logic [15:0] req0_rdata;
  logic        req0_done, req0_err;
  logic        req1_wr = 0, req1_rd = 0;
  logic [23:0] req1_addr = '0;
  logic [15:0] req1_wdata = '0;
  logic [15:0] req1_rdata;
  logic        req1_done, req1_err;
  logic        sdram_wr_req, sdram_rd_req;
  logic        sdram_wr_ack = 0, sdram_rd_ack = 0;
  logic [23:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [15:0] sdram_dout = '0;
  logic        busy, grant_id;

  always #5 sys_clk = ~sys_clk;

  sdram_req_arbiter #(
    .ADDR_W(24), .DATA_W(16), .TIMEOUT(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0_wr(req0_wr), .req0_rd(req0_rd),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rdata(req0_rdata), .req0_done(req0_done),
    .req0_err(req0_err),
    .req1_wr(req1_wr), .req1_rd(req1_rd),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rdata(req1_rdata), .req1_done(req1_done),
    .req1_err(req1_err),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_dout(sdram_dout), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    bit          id;
    bit          wr;
    logic [23:0] addr;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    bit          id;
    bit          err;
    logic [15:0] rdata;
  } cmp_t;

  acc_t        exp_acc[$];
  cmp_t        exp_done[$];
  bit          grant_log[$];
  logic [15:0] mem [logic [23:0]];
  logic [15:0] last_rd [2];
  int          errors = 0, checks = 0;
  int          cyc = 0, free_at = 0;
  bit          mbusy = 0, m_last = 1;
  int          mode = 0, fixed_d = 0;
  bit          overlap = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [23:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return mem.exists(a) ? mem[a] : ((lo * 16'h9e37) ^ 16'h5a5a);
  endfunction

  // Transaction-level arbiter: who wins when the bus is free
  always @(posedge sys_clk) begin : model
    acc_t e;
    bit   v0, v1;
    cyc++;
    if (sys_rst_n && !mbusy && cyc >= free_at) begin
      v0 = req0_wr | req0_rd;
      v1 = req1_wr | req1_rd;
      if (v0 || v1) begin
        e.id    = (v0 && v1) ? ~m_last : v1;
        e.wr    = e.id ? req1_wr : req0_wr;
        e.addr  = e.id ? req1_addr : req0_addr;
        e.wdata = e.id ? req1_wdata : req0_wdata;
        exp_acc.push_back(e);
        m_last = e.id;
        mbusy  = 1;
      end
    end
  end

  // SDRAM controller model: serves requests and predicts completions
  always begin : resp
    acc_t        e;
    cmp_t        c;
    int          d;
    logic [15:0] v;
    @(negedge sys_clk);
    if (sdram_wr_req && sdram_rd_req) overlap = 1;
    if (sys_rst_n && (sdram_wr_req || sdram_rd_req)) begin
      if (exp_acc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: addr 0x%0h, none expected",
                 sdram_addr);
        e.id = 0; e.wr = sdram_wr_req;
        e.addr = sdram_addr; e.wdata = sdram_din;
      end else begin
        e = exp_acc.pop_front();
        chk("op_wr", sdram_wr_req, e.wr);
        chk("grant", grant_id, e.id);
        chk("addr", sdram_addr, e.addr);
        if (e.wr) chk("din", sdram_din, e.wdata);
      end
      grant_log.push_back(grant_id);
      if (mode == 3) begin
        while (sys_rst_n) @(negedge sys_clk);
      end else begin
        d = (mode == 0) ? $urandom_range(0, 3) : fixed_d;
        repeat (d) begin
          if (mode == 0) begin
            if (e.wr) sdram_rd_ack = 1'($urandom_range(0, 1));
            else      sdram_wr_ack = 1'($urandom_range(0, 1));
          end
          @(negedge sys_clk);
        end
        sdram_wr_ack = 0;
        sdram_rd_ack = 0;
        c.id    = e.id;
        c.err   = 0;
        c.rdata = last_rd[e.id];
        if (mode == 2) begin
          c.err = 1;
        end else if (e.wr) begin
          sdram_wr_ack = 1;
          mem[e.addr]  = e.wdata;
        end else begin
          v            = rd_mem(e.addr);
          sdram_rd_ack = 1;
          sdram_dout   = v;
          c.rdata      = v;
          last_rd[e.id] = v;
        end
        exp_done.push_back(c);
        mbusy   = 0;
        free_at = cyc + 3;
        @(negedge sys_clk);
        sdram_wr_ack = 0;
        sdram_rd_ack = 0;
        sdram_dout   = 16'($urandom);
        chk("req_dropped", {sdram_wr_req, sdram_rd_req}, 0);
      end
    end
  end

  always @(negedge sys_clk) begin : mon
    cmp_t        c;
    logic        dn, er;
    logic [15:0] rd;
    for (int n = 0; n < 2; n++) begin
      dn = (n == 1) ? req1_done : req0_done;
      er = (n == 1) ? req1_err : req0_err;
      rd = (n == 1) ? req1_rdata : req0_rdata;
      if (er && !dn) begin
        checks++;
        errors++;
        $display("FAIL err_alone: req%0d err=1 done=0 required err=0", n);
      end
      if (dn) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: req%0d done=1 required 0", n);
        end else begin
          c = exp_done.pop_front();
          chk("done_id", n, c.id);
          chk("done_err", er, c.err);
          chk("rdata", rd, c.rdata);
        end
      end
    end
  end

  task automatic access(input bit id, input bit w, input bit r,
                        input logic [23:0] a, input logic [15:0] wd);
    int need, t;
    bit dn;
    if (id) begin
      req1_addr = a; req1_wdata = wd; req1_wr = w; req1_rd = r;
    end else begin
      req0_addr = a; req0_wdata = wd; req0_wr = w; req0_rd = r;
    end
    need = int'(w) + int'(r);
    while (need > 0) begin
      t = 0;
      do begin
        @(negedge sys_clk);
        t++;
        dn = id ? req1_done : req0_done;
      end while (!dn && t < 400);
      if (!dn) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: req%0d done=0 after %0d cycles, required 1",
                 id, t);
        need = 0;
        if (id) begin req1_wr = 0; req1_rd = 0; end
        else    begin req0_wr = 0; req0_rd = 0; end
      end else begin
        if (id) begin
          if (req1_wr) req1_wr = 0; else req1_rd = 0;
        end else begin
          if (req0_wr) req0_wr = 0; else req0_rd = 0;
        end
        need--;
      end
    end
  endtask

  task automatic model_reset();
    exp_acc.delete();
    exp_done.delete();
    mbusy      = 0;
    free_at    = 0;
    m_last     = 1;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic do_reset();
    sys_rst_n = 0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
    @(negedge sys_clk);
  endtask

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : main
    int t;
    model_reset();
    repeat (3) @(negedge sys_clk);
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_done", {req0_done, req1_done}, 0);
    chk("rst_err", {req0_err, req1_err}, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_rdata", {req0_rdata, req1_rdata}, 0);
    sys_rst_n = 1;
    @(negedge sys_clk);

    mode = 1; fixed_d = 2;
    access(0, 1, 0, 24'h000012, 16'h3412);
    mem[24'h000001] = 16'h7856;
    access(1, 0, 1, 24'h000001, 16'h0);
    repeat (3) @(negedge sys_clk);
    chk("rdata1_held", req1_rdata, 16'h7856);

    do_reset();
    grant_log.delete();
    mode = 0;
    fork
      begin
        for (int i = 0; i < 2; i++)
          access(0, 1, 0, 24'h000020 + 24'(i), 16'($urandom));
      end
      begin
        for (int i = 0; i < 2; i++)
          access(1, 0, 1, 24'h000030 + 24'(i), 16'h0);
      end
    join
    chk("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_order", grant_log[i], i % 2);

    access(0, 1, 1, 24'h000040, 16'hbeef);
    chk("wr_then_rd", req0_rdata, 16'hbeef);

    fork
      begin
        int op;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge sys_clk);
          op = $urandom_range(0, 2);
          access(0, op != 1, op != 0,
                 {19'h0, 1'b0, 4'($urandom)}, 16'($urandom));
        end
      end
      begin
        int op;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge sys_clk);
          op = $urandom_range(0, 2);
          access(1, op != 1, op != 0,
                 {19'h0, 1'b1, 4'($urandom)}, 16'($urandom));
        end
      end
    join

`ifdef ARB_TIMEOUT_EN
    mode = 1; fixed_d = 0;
    access(0, 0, 1, 24'h000005, 16'h0);
    mode = 2; fixed_d = 7;
    access(0, 0, 1, 24'h000006, 16'h0);
    chk("tmo_rdata_kept", req0_rdata, rd_mem(24'h000005));
    mode = 1; fixed_d = 7;
    access(0, 0, 1, 24'h000007, 16'h0);
`endif

    mode = 3;
    req0_addr = 24'h000099; req0_wdata = 16'h1234; req0_wr = 1;
    t = 0;
    while (!sdram_wr_req && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    chk("hang_req_seen", sdram_wr_req, 1);
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 0;
    #1;
    chk("rst_drops_wr_req", sdram_wr_req, 0);
    chk("rst_busy_mid", busy, 0);
    req0_wr = 0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1;
    mode = 1; fixed_d = 1;
    access(0, 1, 0, 24'h000099, 16'h1234);
    access(0, 0, 1, 24'h000099, 16'h0);
    chk("post_rst_rdata", req0_rdata, 16'h1234);

    repeat (4) @(negedge sys_clk);
    chk("acc_queue_empty", exp_acc.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    chk("no_wr_rd_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
